// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with a tick divider and load/start/pause/resume control.
// Each digit borrows from the next; done_o pulses once when the count reaches zero.
module bcd_countdown_timer #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic                  clk100_i,
    input  logic                  rstn_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_value_i,
    input  logic                  start_i,
    input  logic                  pause_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  running_o,
    output logic                  paused_o,
    output logic                  expired_o,
    output logic                  done_o
);

    localparam int unsigned     DivW   = $clog2(TICK_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

    state_e                state_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [4*DIGITS-1:0]   bcd_dec;
    logic [4*DIGITS-1:0]   load_clamped;
    logic [DivW-1:0]       div_q;
    logic                  done_q;
    logic                  tick;
    logic                  borrow;

    // pause_i suppresses the tick so a paused interval never loses a decrement
    assign tick = (state_q == StRun) && !pause_i && (div_q == DivMax);

    always_comb begin
        bcd_dec      = bcd_q;
        load_clamped = load_value_i;
        borrow       = tick;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                bcd_dec[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd0) ? 4'd9 : bcd_q[4*k +: 4] - 4'd1;
            end
            borrow = borrow && (bcd_q[4*k +: 4] == 4'd0);
            if (load_value_i[4*k +: 4] > 4'd9) begin
                load_clamped[4*k +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            bcd_q   <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                state_q <= StIdle;
                bcd_q   <= load_clamped;
                div_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            if (bcd_q == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StRun;
                                div_q   <= '0;
                            end
                        end
                    end
                    StRun: begin
                        if (pause_i) begin
                            state_q <= StPaused;
                        end else if (tick) begin
                            bcd_q <= bcd_dec;
                            div_q <= '0;
                            if (bcd_dec == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            div_q <= div_q + DivW'(1);
                        end
                    end
                    StPaused: begin
                        if (start_i) begin
                            state_q <= StRun;
                        end
                    end
                    StDone: begin
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bcd_o     = bcd_q;
    assign running_o = (state_q == StRun);
    assign paused_o  = (state_q == StPaused);
    assign expired_o = (state_q == StDone);
    assign done_o    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (DIGITS=2, TICK_DIV=4): expected bcd changes and
// done pulses are queued with their arrival cycle and matched by a negedge monitor.
module tb_bcd_countdown_timer;

    localparam int unsigned Digits  = 2;
    localparam int unsigned TickDiv = 4;

    logic       clk100_i = 1'b0;
    logic       rstn_i   = 1'b0;
    logic       load_i   = 1'b0;
    logic [7:0] load_value_i = 8'h00;
    logic       start_i  = 1'b0;
    logic       pause_i  = 1'b0;
    logic [7:0] bcd_o;
    logic       running_o;
    logic       paused_o;
    logic       expired_o;
    logic       done_o;

    bcd_countdown_timer #(
        .DIGITS   (Digits),
        .TICK_DIV (TickDiv)
    ) dut (
        .clk100_i     (clk100_i),
        .rstn_i       (rstn_i),
        .load_i       (load_i),
        .load_value_i (load_value_i),
        .start_i      (start_i),
        .pause_i      (pause_i),
        .bcd_o        (bcd_o),
        .running_o    (running_o),
        .paused_o     (paused_o),
        .expired_o    (expired_o),
        .done_o       (done_o)
    );

    always #5 clk100_i = ~clk100_i;

    // kind 0: bcd_o changes to val; kind 1: done_o high with bcd_o == val
    typedef struct {
        int         kind;
        logic [7:0] val;
        int         cyc;
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] prev_bcd = 8'h00;
    logic [7:0] mdl_bcd = 8'h00;
    int         run_edge;

    always @(posedge clk100_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic got_event(input int kind, input logic [7:0] val);
        ev_t e;
        check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("ev_kind_val", {23'd0, kind[0], val}, {23'd0, e.kind[0], e.val});
            check_eq("ev_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk100_i) begin
        if (bcd_o !== prev_bcd) begin
            prev_bcd = bcd_o;
            got_event(0, bcd_o);
        end
        if (done_o !== 1'b0) begin
            got_event(1, bcd_o);
        end
    end

    function automatic logic [7:0] bcd_minus_one(input logic [7:0] x);
        int v;
        v = 10 * int'(x[7:4]) + int'(x[3:0]) - 1;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push_ev(input int kind, input logic [7:0] val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Inputs change 2 time units after a rising edge; the next rising edge samples them.
    task automatic step();
        @(posedge clk100_i);
        #2;
    endtask

    task automatic do_load(input logic [7:0] val, input logic [7:0] exp_bcd);
        load_i       = 1'b1;
        load_value_i = val;
        if (exp_bcd != mdl_bcd) push_ev(0, exp_bcd, cyc + 1);
        mdl_bcd = exp_bcd;
        step();
        load_i = 1'b0;
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Queue every decrement of a full countdown, the k-th landing at base + TickDiv*k.
    task automatic push_run(input logic [7:0] v, input int base);
        logic [7:0] x;
        int         k;
        x = v;
        k = 0;
        while (x != 8'h00) begin
            k++;
            x = bcd_minus_one(x);
            push_ev(0, x, base + TickDiv * k);
        end
        push_ev(1, 8'h00, base + TickDiv * k);
        mdl_bcd = 8'h00;
    endtask

    initial begin
        repeat (2) step();
        rstn_i = 1'b1;
        step();
        check_eq("rst_bcd", 32'(bcd_o), 32'h00);
        check_eq("rst_running", 32'(running_o), 32'd0);
        check_eq("rst_paused", 32'(paused_o), 32'd0);
        check_eq("rst_expired", 32'(expired_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);

        // 12 counts down to 00 with TickDiv cycles per step
        do_load(8'h12, 8'h12);
        check_eq("ld12_running", 32'(running_o), 32'd0);
        start_pulse();
        run_edge = cyc;
        check_eq("st12_running", 32'(running_o), 32'd1);
        push_run(8'h12, run_edge);
        repeat (50) step();
        check_eq("c12_expired", 32'(expired_o), 32'd1);
        check_eq("c12_running", 32'(running_o), 32'd0);
        check_eq("c12_done_low", 32'(done_o), 32'd0);
        check_eq("c12_sb_empty", 32'(sb.size()), 32'd0);

        // 10 -> 09 needs a borrow across digits
        do_load(8'h10, 8'h10);
        check_eq("ld10_expired", 32'(expired_o), 32'd0);
        start_pulse();
        push_run(8'h10, cyc);
        repeat (42) step();
        check_eq("c10_expired", 32'(expired_o), 32'd1);
        check_eq("c10_sb_empty", 32'(sb.size()), 32'd0);

        // pause mid-interval: the pause edge plus 9 paused cycles freeze the divider for 10
        do_load(8'h05, 8'h05);
        start_pulse();
        run_edge = cyc;
        push_run(8'h05, run_edge + 10);
        step();
        step();
        pause_i = 1'b1;
        step();
        pause_i = 1'b0;
        check_eq("p_paused", 32'(paused_o), 32'd1);
        check_eq("p_running", 32'(running_o), 32'd0);
        repeat (8) step();
        check_eq("p_bcd_frozen", 32'(bcd_o), 32'h05);
        check_eq("p_still_paused", 32'(paused_o), 32'd1);
        start_pulse();
        check_eq("r_running", 32'(running_o), 32'd1);
        check_eq("r_paused", 32'(paused_o), 32'd0);
        repeat (20) step();
        check_eq("p_expired", 32'(expired_o), 32'd1);
        check_eq("p_sb_empty", 32'(sb.size()), 32'd0);

        // zero preset expires at once; a second start gives no pulse
        do_load(8'h00, 8'h00);
        check_eq("z_idle_expired", 32'(expired_o), 32'd0);
        push_ev(1, 8'h00, cyc + 1);
        start_pulse();
        check_eq("z_expired", 32'(expired_o), 32'd1);
        step();
        check_eq("z_done_one_cycle", 32'(done_o), 32'd0);
        start_pulse();
        repeat (3) step();
        check_eq("z_still_expired", 32'(expired_o), 32'd1);
        check_eq("z_sb_empty", 32'(sb.size()), 32'd0);

        // clamping and load-over-start priority
        do_load(8'hFA, 8'h99);
        check_eq("clamp_fa", 32'(bcd_o), 32'h99);
        do_load(8'hB3, 8'h93);
        check_eq("clamp_b3", 32'(bcd_o), 32'h93);
        start_i = 1'b1;
        do_load(8'h34, 8'h34);
        start_i = 1'b0;
        check_eq("ldst_running", 32'(running_o), 32'd0);
        repeat (6) step();
        check_eq("ldst_bcd_held", 32'(bcd_o), 32'h34);
        check_eq("ldst_still_idle", 32'(running_o), 32'd0);

        // asynchronous reset while running at 07
        do_load(8'h08, 8'h08);
        start_pulse();
        run_edge = cyc;
        push_ev(0, 8'h07, run_edge + TickDiv);
        repeat (5) step();
        rstn_i = 1'b0;
        push_ev(0, 8'h00, cyc);
        mdl_bcd = 8'h00;
        step();
        check_eq("rr_bcd", 32'(bcd_o), 32'h00);
        check_eq("rr_running", 32'(running_o), 32'd0);
        check_eq("rr_expired", 32'(expired_o), 32'd0);
        step();
        rstn_i = 1'b1;
        step();
        push_ev(1, 8'h00, cyc + 1);
        start_pulse();
        check_eq("rr_start_expired", 32'(expired_o), 32'd1);
        repeat (2) step();
        check_eq("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
